// File: rtl/axi_rd_arbiter_if.sv
// axi_rd_arbiter_if: one AXI4 read port (AR + R channels); master drives AR and rready, slave drives arready and R.
interface axi_rd_arbiter_if #(
  parameter int ID_W   = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  modport master (
    output arvalid, arid, araddr, arlen, arsize, arburst, rready,
    input  arready, rvalid, rid, rdata, rresp, rlast
  );
  modport slave (
    input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
    output arready, rvalid, rid, rdata, rresp, rlast
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI4 read port between LSU (m0) and IFU (m1), one burst outstanding at a time.
// Define AXI_RD_ARB_RR_EN for round-robin arbitration; otherwise m0 has fixed priority.
module axi_rd_arbiter #(
  parameter int TAG_W  = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input logic              clk,
  input logic              rst,
  axi_rd_arbiter_if.slave  m0,
  axi_rd_arbiter_if.slave  m1,
  axi_rd_arbiter_if.master s,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state_q, state_d;
  logic grant_q, grant_d, last_grant_q, last_grant_d;
  logic [TAG_W:0] arid_q, arid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [7:0] arlen_q, arlen_d;
  logic [2:0] arsize_q, arsize_d;
  logic [1:0] arburst_q, arburst_d;
  logic win, req, idle, dat, acc, r_done, unused;
  // idle is gated with rst so arready is low while reset is held
  assign idle = state_q == IDLE && !rst;
  assign dat = state_q == DATA;
  assign req = m0.arvalid | m1.arvalid;
  assign acc = idle & req;
`ifdef AXI_RD_ARB_RR_EN
  assign win = m0.arvalid & m1.arvalid ? ~last_grant_q : m1.arvalid;
`else
  assign win = m1.arvalid & ~m0.arvalid;
`endif
  assign r_done = dat & s.rvalid & s.rready & s.rlast;
  // steering uses the registered grant only; the returned ID's top bit is ignored
  assign unused = s.rid[TAG_W] ^ last_grant_q;
  always_comb begin
    state_d = acc ? ADDR : (state_q == ADDR && s.arready) ? DATA : r_done ? IDLE : state_q;
    grant_d = acc ? win : grant_q;
    last_grant_d = r_done ? grant_q : last_grant_q;
    arid_d = acc ? {win, win ? m1.arid : m0.arid} : arid_q;
    araddr_d = acc ? (win ? m1.araddr : m0.araddr) : araddr_q;
    arlen_d = acc ? (win ? m1.arlen : m0.arlen) : arlen_q;
    arsize_d = acc ? (win ? m1.arsize : m0.arsize) : arsize_q;
    arburst_d = acc ? (win ? m1.arburst : m0.arburst) : arburst_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_grant_q <= 1'b1;
      arid_q <= '0;
      araddr_q <= '0;
      arlen_q <= '0;
      arsize_q <= '0;
      arburst_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_grant_q <= last_grant_d;
      arid_q <= arid_d;
      araddr_q <= araddr_d;
      arlen_q <= arlen_d;
      arsize_q <= arsize_d;
      arburst_q <= arburst_d;
    end
  end
  assign m0.arready = idle & m0.arvalid & ~win;
  assign m1.arready = idle & win;
  assign s.arvalid = state_q == ADDR;
  assign s.arid = arid_q;
  assign s.araddr = araddr_q;
  assign s.arlen = arlen_q;
  assign s.arsize = arsize_q;
  assign s.arburst = arburst_q;
  assign s.rready = dat & (grant_q ? m1.rready : m0.rready);
  assign m0.rvalid = dat & ~grant_q & s.rvalid;
  assign m1.rvalid = dat & grant_q & s.rvalid;
  assign m0.rid = s.rid[TAG_W-1:0];
  assign m1.rid = s.rid[TAG_W-1:0];
  assign m0.rdata = s.rdata;
  assign m1.rdata = s.rdata;
  assign m0.rresp = s.rresp;
  assign m1.rresp = s.rresp;
  assign m0.rlast = s.rlast;
  assign m1.rlast = s.rlast;
  assign busy = state_q != IDLE;
endmodule
